alu_result_skid: RTL and testbench
==================================

Name: alu_result_skid

Overview:
- Registered output stage placed directly downstream of the combinational ALU element slice (and32/or32/add32 plus result mux).
- Captures the 32-bit ALU result and its op tag, and computes a zero flag alongside the data.
- Presents the result to the writeback/compare logic over a valid/ready handshake.
- A 2-entry skid buffer keeps one-result-per-cycle throughput while breaking the combinational ready path back into the ALU.

Parameters:
- WIDTH, 32, result data width; must match the ALU element width.
- OPW, 3, op-tag width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- flush  input  1  synchronous clear of all buffered entries.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  buffer can accept; registered.
- in_res  input  WIDTH  ALU result (e.g. and32 res).
- in_op  input  OPW  op tag carried with the result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_res  output  WIDTH  head result.
- out_op  output  OPW  head op tag.
- out_zero  output  1  1 when out_res == 0; registered with the data.
- occupancy  output  2  entries held (0..2).

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); rst_n low clears state immediately, independent of clk.
- Reset values:
  - out_valid=0, in_ready=1, occupancy=0.
  - out_res=0, out_op=0, out_zero=1.
  - skid entry cleared.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_valid while in_ready=0 is ignored; the upstream must hold.
  - Once out_valid=1, out_res/out_op/out_zero stay stable until pop.
- Latency: a push in cycle N makes the data visible on out_* in cycle N+1 when the buffer was empty. No combinational path from in_* to out_*, or from out_ready to in_ready.
- States (encoded by occupancy):
  - EMPTY (0): push -> ONE, head loaded from in_*.
  - ONE (1):
    - push & !pop -> TWO, data into skid, in_ready drops next cycle.
    - push & pop -> ONE, head reloaded from in_*.
    - !push & pop -> EMPTY.
  - TWO (2), in_ready=0: pop -> ONE, skid moves to head, in_ready=1 next cycle. No push is possible.
- Ordering: strict FIFO; skid data is never presented before the older head.
- out_zero is computed from the value being written into the head register, never from out_res afterward.
- flush:
  - Next edge forces EMPTY, clears skid, in_ready=1; out_res/out_op need not clear.
  - Priority over a simultaneous push or pop; the pushed result is discarded.
- occupancy never exceeds 2 and never underflows; pop in EMPTY is impossible because out_valid=0.
- Width rules: no arithmetic on data except the WIDTH-wide reduction-NOR for out_zero; the op tag passes through unchanged.

Decomposition:
- Shared header alu_defs.vh holds:
  - op-tag constants: AND=0, OR=1, ADD=2, SUB=3, SLT=4, NOR=5, SRL=6, XOR=7.
  - OPW=3 and WIDTH=32 defaults.
- Both the ALU mux and this block include the header.
- Single module; no sub-module is needed. The head and skid registers are two instances of the same {res, op, zero} bundle, written inline.

Test Plan:
- Reset mid-stream: fill to TWO, assert rst_n=0 between edges -> immediately out_valid=0, in_ready=1, occupancy=0, out_zero=1.
- Single transfer: out_ready=1, push in_res=32'hFFFFFFFF (AND of all-ones), op=AND -> next cycle out_valid=1, out_res=FFFFFFFF, out_zero=0, out_op=0; popped that cycle; occupancy returns to 0.
- Zero flag: push in_res=0 (AND of 0,0) -> out_zero=1 alongside out_res=0; the following push of 32'h00000001 -> out_zero=0.
- Backpressure/skid:
  - out_ready=0, push A=1 then B=2 on consecutive cycles -> occupancy=2, in_ready=0, an attempted push C=3 is ignored.
  - Raise out_ready -> outputs A, then B, then accepts C; order 1, 2, 3; no loss or duplication.
- Streaming: 100 back-to-back pushes of incrementing values, out_ready=1 -> one output per cycle, in_ready never drops, values in order.
- Flush collision: at occupancy=2, assert flush with in_valid=1 and out_ready=1 -> next cycle occupancy=0, out_valid=0, in_ready=1; flushed and pushed data never appear.

Source files
------------

// File: rtl/alu_result_skid_pkg.sv
// Shared definitions for the ALU result output stage: default widths,
// op-tag encodings used by the ALU result mux, and the occupancy states
// of the two-entry skid buffer.
package alu_result_skid_pkg;

   localparam int ALU_WIDTH = 32;
   localparam int ALU_OPW   = 3;

   // Op tags carried alongside each ALU result
   typedef enum logic [ALU_OPW-1:0] {
      OP_AND = 3'd0,
      OP_OR  = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_SLT = 3'd4,
      OP_NOR = 3'd5,
      OP_SRL = 3'd6,
      OP_XOR = 3'd7
   } alu_op_e;

   // Buffer state doubles as the occupancy count
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_e;

endpackage

// File: rtl/alu_result_skid.sv
// Registered ALU result stage with a 2-entry skid buffer and zero flag.
// Latency: push in cycle N is visible on out_* in cycle N+1 when empty.
// Backpressure: in_ready is a flop (low only when both entries are held),
// so out_ready never reaches in_ready combinationally.
module alu_result_skid
   import alu_result_skid_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_res,
   input  logic [OPW-1:0]   in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic [OPW-1:0]   out_op,
   output logic             out_zero,
   output logic [1:0]       occupancy
);

   occ_e             state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] head_res_q, head_res_d;
   logic [OPW-1:0]   head_op_q, head_op_d;
   logic             head_zero_q, head_zero_d;
   logic [WIDTH-1:0] skid_res_q, skid_res_d;
   logic [OPW-1:0]   skid_op_q, skid_op_d;
   logic             skid_zero_q, skid_zero_d;

   logic push, pop;
   logic load_head_in, load_head_skid, load_skid, clr_skid;
   logic in_zero;

   assign push    = in_valid & in_ready_q;
   assign pop     = (state_q != OCC_EMPTY) & out_ready;
   assign in_zero = ~|in_res;

   // State register: occupancy, registered ready, head and skid entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= OCC_EMPTY;
         in_ready_q  <= 1'b1;
         head_res_q  <= '0;
         head_op_q   <= '0;
         head_zero_q <= 1'b1;
         skid_res_q  <= '0;
         skid_op_q   <= '0;
         skid_zero_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         head_res_q  <= head_res_d;
         head_op_q   <= head_op_d;
         head_zero_q <= head_zero_d;
         skid_res_q  <= skid_res_d;
         skid_op_q   <= skid_op_d;
         skid_zero_q <= skid_zero_d;
      end
   end

   // Next-state: occupancy transitions and which entry gets loaded from where
   always_comb begin
      state_d        = state_q;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
      clr_skid       = 1'b0;
      if (flush) begin
         // Flush wins over any push/pop in the same cycle
         state_d  = OCC_EMPTY;
         clr_skid = 1'b1;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (push) begin
                  state_d      = OCC_ONE;
                  load_head_in = 1'b1;
               end
            end
            OCC_ONE: begin
               if (push && !pop) begin
                  state_d   = OCC_TWO;
                  load_skid = 1'b1;
               end else if (push && pop) begin
                  load_head_in = 1'b1;
               end else if (pop) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               // in_ready is low here, so push cannot occur
               if (pop) begin
                  state_d        = OCC_ONE;
                  load_head_skid = 1'b1;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   // Datapath: entry updates; zero flag is taken from the value being written
   always_comb begin
      head_res_d  = head_res_q;
      head_op_d   = head_op_q;
      head_zero_d = head_zero_q;
      skid_res_d  = skid_res_q;
      skid_op_d   = skid_op_q;
      skid_zero_d = skid_zero_q;
      if (load_head_in) begin
         head_res_d  = in_res;
         head_op_d   = in_op;
         head_zero_d = in_zero;
      end else if (load_head_skid) begin
         head_res_d  = skid_res_q;
         head_op_d   = skid_op_q;
         head_zero_d = skid_zero_q;
      end
      if (clr_skid) begin
         skid_res_d  = '0;
         skid_op_d   = '0;
         skid_zero_d = 1'b1;
      end else if (load_skid) begin
         skid_res_d  = in_res;
         skid_op_d   = in_op;
         skid_zero_d = in_zero;
      end
      in_ready_d = (state_d != OCC_TWO);
   end

   // Outputs: everything driven straight from flops
   always_comb begin
      out_valid = (state_q != OCC_EMPTY);
      in_ready  = in_ready_q;
      out_res   = head_res_q;
      out_op    = head_op_q;
      out_zero  = head_zero_q;
      occupancy = state_q;
   end

endmodule

// File: tb/tb_alu_result_skid.sv
// Bench for alu_result_skid: directed vector table, reset/streaming
// sequences, and randomized traffic checked against a queue model.
module tb_alu_result_skid;
   import alu_result_skid_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_res;
   logic [2:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [2:0]  out_op;
   logic        out_zero;
   logic [1:0]  occupancy;

   int tests;
   int fails;

   alu_result_skid dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_op    (out_op),
      .out_zero  (out_zero),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: an ordered list of accepted results, at most two deep
   typedef struct {
      logic [31:0] res;
      logic [2:0]  op;
   } ent_t;
   ent_t mq[$];

   typedef struct {
      logic        iv;
      logic        ordy;
      logic        fl;
      logic [31:0] res;
      logic [2:0]  op;
      logic        e_valid;
      logic [31:0] e_res;
      logic [2:0]  e_op;
      logic        e_zero;
      logic [1:0]  e_occ;
      logic        e_ir;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance past the edge, update the model
   task automatic cycle(input logic iv, input logic ordy, input logic fl,
                        input logic [31:0] r, input logic [2:0] o);
      logic acc, pp;
      ent_t e;
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      in_res    = r;
      in_op     = o;
      acc = iv && (mq.size() < 2);
      pp  = ordy && (mq.size() > 0);
      @(posedge clk);
      #1;
      if (fl) begin
         mq.delete();
      end else begin
         if (pp) void'(mq.pop_front());
         if (acc) begin
            e.res = r;
            e.op  = o;
            mq.push_back(e);
         end
      end
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, mq.size() > 0});
      chk({tag, ".occ"}, {30'd0, occupancy}, mq.size());
      chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (mq.size() > 0) begin
         chk({tag, ".res"}, out_res, mq[0].res);
         chk({tag, ".op"}, {29'd0, out_op}, {29'd0, mq[0].op});
         chk({tag, ".zero"}, {31'd0, out_zero}, {31'd0, mq[0].res == 32'd0});
      end
   endtask

   vec_t vt[18];

   initial begin
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      in_res = '0;
      in_op = '0;

      //              iv ordy fl  res           op      valid res           op      zero occ  ir
      vt[0]  = '{1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, OP_AND, 1'b1, 32'hFFFFFFFF, OP_AND, 1'b0, 2'd1, 1'b1};
      vt[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0,        OP_AND, 1'b1, 32'h0,        OP_AND, 1'b1, 2'd1, 1'b1};
      vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[4]  = '{1'b1, 1'b1, 1'b0, 32'h1,        OP_ADD, 1'b1, 32'h1,        OP_ADD, 1'b0, 2'd1, 1'b1};
      vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h1,        OP_AND, 1'b1, 32'h1,        OP_AND, 1'b0, 2'd1, 1'b1};
      vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h2,        OP_OR,  1'b1, 32'h1,        OP_AND, 1'b0, 2'd2, 1'b0};
      vt[8]  = '{1'b1, 1'b0, 1'b0, 32'h3,        OP_ADD, 1'b1, 32'h1,        OP_AND, 1'b0, 2'd2, 1'b0};
      vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h3,        OP_ADD, 1'b1, 32'h2,        OP_OR,  1'b0, 2'd1, 1'b1};
      vt[10] = '{1'b1, 1'b1, 1'b0, 32'h3,        OP_ADD, 1'b1, 32'h3,        OP_ADD, 1'b0, 2'd1, 1'b1};
      vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[12] = '{1'b1, 1'b0, 1'b0, 32'd10,       OP_SUB, 1'b1, 32'd10,       OP_SUB, 1'b0, 2'd1, 1'b1};
      vt[13] = '{1'b1, 1'b0, 1'b0, 32'd11,       OP_SLT, 1'b1, 32'd10,       OP_SUB, 1'b0, 2'd2, 1'b0};
      vt[14] = '{1'b1, 1'b1, 1'b1, 32'd12,       OP_NOR, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[15] = '{1'b0, 1'b0, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};
      vt[16] = '{1'b1, 1'b0, 1'b0, 32'd13,       OP_NOR, 1'b1, 32'd13,       OP_NOR, 1'b0, 2'd1, 1'b1};
      vt[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        OP_AND, 1'b0, 32'h0,        OP_AND, 1'b0, 2'd0, 1'b1};

      // Reset state
      #12;
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst.occ", {30'd0, occupancy}, 32'd0);
      chk("rst.res", out_res, 32'd0);
      chk("rst.op", {29'd0, out_op}, 32'd0);
      chk("rst.zero", {31'd0, out_zero}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed vector table
      for (int i = 0; i < 18; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         cycle(vt[i].iv, vt[i].ordy, vt[i].fl, vt[i].res, vt[i].op);
         chk({t, ".valid"}, {31'd0, out_valid}, {31'd0, vt[i].e_valid});
         chk({t, ".occ"}, {30'd0, occupancy}, {30'd0, vt[i].e_occ});
         chk({t, ".in_ready"}, {31'd0, in_ready}, {31'd0, vt[i].e_ir});
         if (vt[i].e_valid) begin
            chk({t, ".res"}, out_res, vt[i].e_res);
            chk({t, ".op"}, {29'd0, out_op}, {29'd0, vt[i].e_op});
            chk({t, ".zero"}, {31'd0, out_zero}, {31'd0, vt[i].e_zero});
         end
      end

      // Reset mid-stream: fill to two entries, then drop rst_n between edges
      cycle(1'b1, 1'b0, 1'b0, 32'hA5, OP_XOR);
      cycle(1'b1, 1'b0, 1'b0, 32'h5A, OP_SRL);
      chk("midrst.pre_occ", {30'd0, occupancy}, 32'd2);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      mq.delete();
      chk("midrst.valid", {31'd0, out_valid}, 32'd0);
      chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst.occ", {30'd0, occupancy}, 32'd0);
      chk("midrst.zero", {31'd0, out_zero}, 32'd1);
      #4;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_model("post_rst");

      // Streaming: back-to-back pushes with the consumer always ready
      for (int i = 0; i < 100; i++) begin
         cycle(1'b1, 1'b1, 1'b0, 32'd1000 + i, 3'(i));
         chk("stream.in_ready", {31'd0, in_ready}, 32'd1);
         chk("stream.res", out_res, 32'd1000 + i);
         chk("stream.valid", {31'd0, out_valid}, 32'd1);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 3'd0);
      chk_model("stream_drain");

      // Randomized traffic against the queue model
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r;
         r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 40) == 0, r, 3'($urandom_range(0, 7)));
         chk_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
